// File: rtl/setuphold_stim_gen.sv
// Setup/hold stimulus generator: presents a data word, raises a strobe a programmed
// number of cycles later, then invalidates the word a programmed number of cycles
// after the strobe rise. Zero-margin and violating windows are generated as well.
module setuphold_stim_gen #(
  parameter int unsigned   DW       = 8,
  parameter int unsigned   CW       = 8,
  parameter int unsigned   STRB_HI  = 2,
  parameter logic [DW-1:0] IDLE_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [CW-1:0] in_setup,
  input  logic [CW-1:0] in_hold,
  input  logic          abort,
  output logic [DW-1:0] data_out,
  output logic          strb,
  output logic          busy,
  output logic          done
);

  // One spare bit so a full-scale setup or hold count never wraps.
  localparam int unsigned CntW = CW + 1;
  localparam logic [CntW-1:0] StrbHi = CntW'(STRB_HI);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSetup = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   word_q, word_d;
  logic [CW-1:0]   setup_q, setup_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [DW-1:0]   data_q, data_d;
  logic            strb_q, strb_d;
  logic            done_q, done_d;
  logic [CntW-1:0] hold_ext;
  logic [CntW-1:0] end_cnt;

  assign hold_ext = {1'b0, hold_q};
  // The transaction ends once both the strobe pulse and the hold window have elapsed.
  assign end_cnt  = (StrbHi > hold_ext) ? StrbHi : hold_ext;

  // Next-state logic; cnt counts edges since accept (SETUP) or since strobe rise (HOLD).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    setup_d = setup_q;
    hold_d  = hold_q;
    data_d  = data_q;
    strb_d  = strb_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          word_d  = in_data;
          setup_d = in_setup;
          // Zero/zero is coerced to a one-cycle hold so data never changes twice per edge.
          hold_d  = (in_setup == '0 && in_hold == '0) ? CW'(1) : in_hold;
          data_d  = in_data;
          cnt_d   = CntW'(1);
          if (in_setup == '0) begin
            strb_d  = 1'b1;
            state_d = StHold;
          end else begin
            state_d = StSetup;
          end
        end
      end
      StSetup: begin
        if (abort) begin
          state_d = StIdle;
          strb_d  = 1'b0;
          data_d  = IDLE_VAL;
        end else if (cnt_q == {1'b0, setup_q}) begin
          strb_d  = 1'b1;
          state_d = StHold;
          cnt_d   = CntW'(1);
          // Zero hold: the data invalidates on the strobe edge itself.
          if (hold_q == '0) data_d = ~word_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (abort) begin
          state_d = StIdle;
          strb_d  = 1'b0;
          data_d  = IDLE_VAL;
        end else begin
          if (cnt_q == StrbHi)   strb_d = 1'b0;
          if (cnt_q == hold_ext) data_d = ~word_q;
          if (cnt_q == end_cnt) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        strb_d  = 1'b0;
        data_d  = IDLE_VAL;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
      setup_q <= '0;
      hold_q  <= '0;
      data_q  <= IDLE_VAL;
      strb_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      setup_q <= setup_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = ~in_ready;
  assign data_out = data_q;
  assign strb     = strb_q;
  assign done     = done_q;

endmodule
